// File: rtl/l1_dcache_ctrl_if.sv
// CPU-side request/response bus of the L1 data cache controller.
interface l1_dcache_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int WORD_W = 32
);
  // Handshake: a request transfers on the rising edge where cpu_req and
  // cpu_ready are both high. cpu_we/cpu_addr/cpu_wdata are sampled at that
  // edge only. Completion is a one-cycle cpu_valid pulse with no backpressure.
  // cpu_rdata carries read data with the pulse and holds until the next
  // completion. cpu_ready may already be high in the cycle cpu_valid pulses.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [WORD_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_valid, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_valid, cpu_rdata
  );
endinterface

// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// Sequences a single-port tag/valid RAM and data RAM (read-first, 1-cycle
// latency), refills lines from memory and writes words through to memory.
// Valid bits are swept to zero after reset and on flush.
module l1_dcache_ctrl #(
  parameter  int TAG_W  = 9,
  parameter  int IDX_W  = 6,
  parameter  int OFF_W  = 4,
  parameter  int LINE_W = 128,
  parameter  int WORD_W = 32,
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  l1_dcache_ctrl_if.slave     cpu,
  output logic                busy_o,
  // tag/valid RAM, data = {valid, tag}
  output logic                tgv_we_o,
  output logic [IDX_W-1:0]    tgv_addr_o,
  output logic [TAG_W:0]      tgv_data_o,
  input  logic [TAG_W:0]      tgv_data_i,
  // data RAM
  output logic                data_we_o,
  output logic [IDX_W-1:0]    data_addr_o,
  output logic [LINE_W-1:0]   data_wdata_o,
  input  logic [LINE_W-1:0]   data_rdata_i,
  // next-level memory
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [WORD_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [LINE_W-1:0]   mem_rdata_i,
  // controller state, for observation only
  output logic [2:0]          dbg_state_o
);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'((2 ** IDX_W) - 1);
  localparam logic [ADDR_W-1:0] WORD_MSK  = ~ADDR_W'(3);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_LOOKUP = 3'd2,
    S_REFILL = 3'd3,
    S_FILL   = 3'd4,
    S_MEM_WR = 3'd5,
    S_FLUSH  = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [WORD_W-1:0]   r_wdata;
  logic [LINE_W-1:0]   r_line;
  logic                r_cpu_valid;
  logic [WORD_W-1:0]   r_cpu_rdata;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_cpu_idx;
  logic [OFF_W-3:0]    w_sel;
  int                  w_sel_lsb;
  logic                w_hit;
  logic [WORD_W-1:0]   w_ram_word;
  logic [WORD_W-1:0]   w_line_word;
  logic [LINE_W-1:0]   w_merged;
  logic                w_accept;
  logic                w_valid_set;
  logic                w_rdata_load;
  logic [WORD_W-1:0]   w_rdata_val;

  assign w_tag       = r_addr[ADDR_W-1 -: TAG_W];
  assign w_idx       = r_addr[OFF_W +: IDX_W];
  assign w_cpu_idx   = cpu.cpu_addr[OFF_W +: IDX_W];
  assign w_sel       = r_addr[OFF_W-1:2];
  assign w_sel_lsb   = int'(w_sel) * WORD_W;
  assign w_hit       = tgv_data_i[TAG_W] & (tgv_data_i[TAG_W-1:0] == w_tag);
  assign w_ram_word  = data_rdata_i[w_sel_lsb +: WORD_W];
  assign w_line_word = r_line[w_sel_lsb +: WORD_W];

  assign cpu.cpu_valid = r_cpu_valid;
  assign cpu.cpu_rdata = r_cpu_rdata;
  assign dbg_state_o   = r_state;

  // Write-hit merge: the line just read, with the addressed word replaced.
  always_comb begin
    w_merged = data_rdata_i;
    w_merged[w_sel_lsb +: WORD_W] = r_wdata;
  end

  // State register; reset always restarts the valid-bit sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next state and all RAM/memory/CPU control outputs.
  always_comb begin
    w_state_nxt   = r_state;
    cpu.cpu_ready = 1'b0;
    busy_o        = 1'b0;
    tgv_we_o      = 1'b0;
    tgv_addr_o    = w_idx;
    tgv_data_o    = '0;
    data_we_o     = 1'b0;
    data_addr_o   = w_idx;
    data_wdata_o  = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    w_accept      = 1'b0;
    w_valid_set   = 1'b0;
    w_rdata_load  = 1'b0;
    w_rdata_val   = '0;
    case (r_state)
      S_INIT, S_FLUSH: begin
        busy_o      = 1'b1;
        tgv_we_o    = 1'b1;
        tgv_addr_o  = r_cnt;
        data_addr_o = r_cnt;
        if (r_cnt == LAST_IDX) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        cpu.cpu_ready = 1'b1;
        // Present the index now so tag and data are ready in LOOKUP.
        tgv_addr_o    = w_cpu_idx;
        data_addr_o   = w_cpu_idx;
        if (flush_i) begin
          w_state_nxt = S_FLUSH;
        end else if (cpu.cpu_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit && !r_we) begin
          w_rdata_load = 1'b1;
          w_rdata_val  = w_ram_word;
          w_valid_set  = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if (w_hit && r_we) begin
          data_we_o    = 1'b1;
          data_wdata_o = w_merged;
          w_state_nxt  = S_MEM_WR;
        end else if (!r_we) begin
          w_state_nxt  = S_REFILL;
        end else begin
          // Write miss: no allocate, memory write only.
          w_state_nxt  = S_MEM_WR;
        end
      end
      S_REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {w_tag, w_idx, OFF_W'(0)};
        if (mem_ack_i) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        tgv_we_o     = 1'b1;
        tgv_data_o   = {1'b1, w_tag};
        data_we_o    = 1'b1;
        data_wdata_o = r_line;
        w_rdata_load = 1'b1;
        w_rdata_val  = w_line_word;
        w_valid_set  = 1'b1;
        w_state_nxt  = S_IDLE;
      end
      S_MEM_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = r_addr & WORD_MSK;
        mem_wdata_o = r_wdata;
        if (mem_ack_i) begin
          w_valid_set = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  // Datapath: sweep counter, request latch, refill line, CPU response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_line      <= '0;
      r_cpu_valid <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      if (r_state == S_INIT || r_state == S_FLUSH) r_cnt <= r_cnt + IDX_W'(1);
      else                                         r_cnt <= '0;
      if (w_accept) begin
        r_addr  <= cpu.cpu_addr;
        r_we    <= cpu.cpu_we;
        r_wdata <= cpu.cpu_wdata;
      end
      if (r_state == S_REFILL && mem_ack_i) r_line <= mem_rdata_i;
      r_cpu_valid <= w_valid_set;
      if (w_rdata_load) r_cpu_rdata <= w_rdata_val;
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
module tb_l1_dcache_ctrl;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  logic flush_i;
  always #5 clk_i = ~clk_i;

  logic         busy_o;
  logic         tgv_we_o;
  logic [5:0]   tgv_addr_o;
  logic [9:0]   tgv_data_o;
  logic [9:0]   tgv_data_i;
  logic         data_we_o;
  logic [5:0]   data_addr_o;
  logic [127:0] data_wdata_o;
  logic [127:0] data_rdata_i;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [18:0]  mem_addr_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_ack_i;
  logic [127:0] mem_rdata_i;
  logic [2:0]   dbg_state_o;

  l1_dcache_ctrl_if #(.ADDR_W(19), .WORD_W(32)) cpu_bus ();

  l1_dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .cpu          (cpu_bus),
    .busy_o       (busy_o),
    .tgv_we_o     (tgv_we_o),
    .tgv_addr_o   (tgv_addr_o),
    .tgv_data_o   (tgv_data_o),
    .tgv_data_i   (tgv_data_i),
    .data_we_o    (data_we_o),
    .data_addr_o  (data_addr_o),
    .data_wdata_o (data_wdata_o),
    .data_rdata_i (data_rdata_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- RAM models (single-port, read-first) ----------------
  logic [9:0]   tgv_mem  [64];
  logic [127:0] data_mem [64];

  initial begin
    for (int i = 0; i < 64; i++) begin
      tgv_mem[i]  = 10'($urandom);
      data_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  always @(posedge clk_i) begin
    tgv_data_i <= tgv_mem[tgv_addr_o];
    if (tgv_we_o) tgv_mem[tgv_addr_o] <= tgv_data_o;
  end

  always @(posedge clk_i) begin
    data_rdata_i <= data_mem[data_addr_o];
    if (data_we_o) data_mem[data_addr_o] <= data_wdata_o;
  end

  // ---------------- reference model & scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];       // expected read data, in completion order
  logic [51:0] mem_exp_q[$];   // expected memory request {we, addr, wdata}

  logic        ref_valid [64];
  logic [8:0]  ref_tag   [64];
  logic [31:0] ref_mem   [int];  // architectural memory as the CPU sees it
  logic [31:0] bk_mem    [int];  // contents of the next-level memory

  function automatic logic [31:0] def_word(input int wa);
    logic [31:0] t;
    t = wa;
    return {t[15:0] ^ 16'hc3a5, t[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input int wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : def_word(wa);
  endfunction

  function automatic logic [31:0] bk_rd(input int wa);
    return bk_mem.exists(wa) ? bk_mem[wa] : def_word(wa);
  endfunction

  function automatic logic [127:0] bk_line(input int lwa);
    return {bk_rd(lwa + 3), bk_rd(lwa + 2), bk_rd(lwa + 1), bk_rd(lwa)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // Called at #1 after a posedge with the sweep at count 0.
  task automatic sweep_check(input string tag);
    for (int k = 0; k < 64; k++) begin
      check({tag, "_busy"},  busy_o, 1);
      check({tag, "_ready"}, cpu_bus.cpu_ready, 0);
      check({tag, "_tgv_we"}, tgv_we_o, 1);
      check({tag, "_tgv_addr"}, tgv_addr_o, k);
      check({tag, "_tgv_data"}, tgv_data_o, 0);
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
    end
    cpu_bus.cpu_req = 1'b0;
    check({tag, "_done_ready"}, cpu_bus.cpu_ready, 1);
    check({tag, "_done_busy"}, busy_o, 0);
  endtask

  // One CPU transaction; also plays the next-level memory.
  task automatic do_req(input logic we, input logic [18:0] addr, input logic [31:0] wdata);
    int          wa, idx, lat, n_req, n_tgv, n_data, wait_left;
    logic [8:0]  tag;
    logic        hit, acked, got, pulse_chk;
    int          exp_lat;
    logic [51:0] mexp;

    for (int i = 0; i < 200 && !cpu_bus.cpu_ready; i++) begin
      @(posedge clk_i); #1;
    end
    if (!cpu_bus.cpu_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end

    wa  = int'(addr[18:2]);
    idx = int'(addr[9:4]);
    tag = addr[18:10];
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    if (!we) begin
      exp_q.push_back(ref_rd(wa));
      if (!hit) begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
        mem_exp_q.push_back({1'b0, addr & 19'h7fff0, 32'h0});
      end
    end else begin
      ref_mem[wa] = wdata;
      mem_exp_q.push_back({1'b1, addr & 19'h7fffc, wdata});
    end

    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_addr  = addr;
    cpu_bus.cpu_wdata = wdata;
    @(posedge clk_i); #1;
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_wdata = 32'($urandom);

    lat = 1; n_req = 0; n_tgv = 0; n_data = 0;
    acked = 1'b0; got = 1'b0;
    wait_left = $urandom_range(0, 3);
    for (int c = 0; c < 100; c++) begin
      if (cpu_bus.cpu_valid) begin
        got = 1'b1;
        break;
      end
      if (tgv_we_o)  n_tgv++;
      if (data_we_o) n_data++;
      if (mem_req_o) n_req++;
      if (mem_req_o && !acked) begin
        if (n_req == 1) begin
          if (mem_exp_q.size() == 0) begin
            check("mem_unexpected_req", 1, 0);
          end else begin
            mexp = mem_exp_q.pop_front();
            check("mem_req_fields", {mem_we_o, mem_addr_o, mem_we_o ? mem_wdata_o : 32'h0}, mexp);
          end
        end
        if (wait_left == 0) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) bk_mem[int'(mem_addr_o[18:2])] = mem_wdata_o;
          else          mem_rdata_i = bk_line(int'(mem_addr_o[18:2]));
          acked = 1'b1;
        end else begin
          wait_left--;
        end
      end
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      lat++;
    end

    if (!got) begin
      check("valid_timeout", 0, 1);
      return;
    end
    check("mem_missing", mem_exp_q.size(), 0);
    mem_exp_q.delete();

    if (!we && hit)  exp_lat = 2;
    else if (!we)    exp_lat = 3 + n_req;
    else             exp_lat = 2 + n_req;
    check("latency", lat, exp_lat);
    check("mem_used", n_req != 0, we || !hit);
    check("tgv_writes", n_tgv, (!we && !hit) ? 1 : 0);
    check("data_writes", n_data, ((!we && !hit) || (we && hit)) ? 1 : 0);
    if (!we) check("rdata", cpu_bus.cpu_rdata, exp_q.pop_front());

    pulse_chk = 1'($urandom_range(0, 1));
    if (pulse_chk) begin
      @(posedge clk_i); #1;
      check("valid_pulse", cpu_bus.cpu_valid, 0);
      if (!we) check("rdata_hold", cpu_bus.cpu_rdata, ref_rd(wa));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #500000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [18:0] ra;
    logic        rwe;

    rst_i = 1'b1; flush_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0;
    cpu_bus.cpu_addr = '0; cpu_bus.cpu_wdata = '0;
    model_clear();

    // Preset line 0x120 in both memories.
    bk_mem[32'h48] = 32'haaaa0000; ref_mem[32'h48] = 32'haaaa0000;
    bk_mem[32'h49] = 32'hbbbb0001; ref_mem[32'h49] = 32'hbbbb0001;
    bk_mem[32'h4a] = 32'hcccc0002; ref_mem[32'h4a] = 32'hcccc0002;
    bk_mem[32'h4b] = 32'hdddd0003; ref_mem[32'h4b] = 32'hdddd0003;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_valid", cpu_bus.cpu_valid, 0);
    check("rst_rdata", cpu_bus.cpu_rdata, 0);
    check("rst_mem_req", mem_req_o, 0);
    check("rst_data_we", data_we_o, 0);
    rst_i = 1'b0;
    sweep_check("init");

    // Cold read, then hit on the same line.
    do_req(1'b0, 19'h00124, 32'h0);
    check("fill_tgv_idx18", tgv_mem[18], {1'b1, 9'd0});
    do_req(1'b0, 19'h00124, 32'h0);

    // Write hit merges one word, then read it back.
    do_req(1'b1, 19'h00128, 32'h12345678);
    check("whit_line_idx18", data_mem[18],
          {32'hdddd0003, 32'h12345678, 32'hbbbb0001, 32'haaaa0000});
    do_req(1'b0, 19'h00128, 32'h0);

    // Write miss: memory only, then the read misses and refills.
    do_req(1'b1, 19'h00a00, 32'hcafef00d);
    do_req(1'b0, 19'h00a00, 32'h0);

    // Conflict on index 18.
    do_req(1'b0, 19'h00524, 32'h0);
    do_req(1'b0, 19'h00124, 32'h0);

    // Flush with a request pending; request must wait for the sweep.
    flush_i = 1'b1;
    cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 19'h00124;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    model_clear();
    sweep_check("flush");
    check("flush_no_accept", mem_exp_q.size(), 0);
    do_req(1'b0, 19'h00124, 32'h0);

    // Reset while waiting on a refill; the late ack must be ignored.
    cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 19'h00e40;
    @(posedge clk_i); #1;
    cpu_bus.cpu_req = 1'b0;
    for (int i = 0; i < 10 && !mem_req_o; i++) begin
      @(posedge clk_i); #1;
    end
    check("rst_refill_reached", mem_req_o, 1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("rst_mid_mem_req", mem_req_o, 0);
    check("rst_mid_valid", cpu_bus.cpu_valid, 0);
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    mem_rdata_i = {4{32'hdeadbeef}};
    model_clear();
    sweep_check("rst_mid");
    do_req(1'b0, 19'h00e40, 32'h0);

    // Randomized mix over a few tags and indices to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      ra  = {9'($urandom_range(0, 3)), 6'($urandom_range(16, 23)),
             2'($urandom_range(0, 3)), 2'b00};
      rwe = ($urandom_range(0, 99) < 30);
      do_req(rwe, ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
